// File: rtl/obj_line_pkg.sv
// Shared types for the OBJ scanline streamer: entry layout, stream FSM states
// and the default line width.
// Build option: OBJ_WINDOW_EN adds a per-entry OBJ-window bit.
package obj_line_pkg;

    localparam int OBJ_LINE_WIDTH = 240;

    typedef struct packed {
`ifdef OBJ_WINDOW_EN
        logic       win;
`endif
        logic       opaque;
        logic [1:0] prio;
        logic [7:0] pal;
    } obj_line_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } obj_stream_state_t;

    // A new pixel takes the slot when the slot is empty or the new priority
    // is strictly better (numerically lower). Equal priority keeps the
    // earlier pixel, which is the lower OAM index.
    function automatic logic obj_pixel_wins(input obj_line_entry_t stored,
                                            input logic [1:0]      new_prio);
        return (!stored.opaque) || (new_prio < stored.prio);
    endfunction

endpackage

// File: rtl/obj_line_streamer_if.sv
// Write port from the OBJ renderer and pixel stream to the compositor.
// Build option: OBJ_WINDOW_EN adds wr_win / out_win.
interface obj_line_streamer_if #(
    parameter int XW = 8
) ();

    logic          wr_en;
    logic [XW-1:0] wr_x;
    logic [7:0]    wr_pal;
    logic [1:0]    wr_prio;
`ifdef OBJ_WINDOW_EN
    logic          wr_win;
    logic          out_win;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [XW-1:0] out_x;
    logic [7:0]    out_pal;
    logic [1:0]    out_prio;
    logic          out_transparent;

    // Renderer / compositor side.
    modport master (
`ifdef OBJ_WINDOW_EN
        output wr_win,
        input  out_win,
`endif
        output wr_en,
        output wr_x,
        output wr_pal,
        output wr_prio,
        output out_ready,
        input  out_valid,
        input  out_x,
        input  out_pal,
        input  out_prio,
        input  out_transparent
    );

    // Line buffer side.
    modport slave (
`ifdef OBJ_WINDOW_EN
        input  wr_win,
        output out_win,
`endif
        input  wr_en,
        input  wr_x,
        input  wr_pal,
        input  wr_prio,
        input  out_ready,
        output out_valid,
        output out_x,
        output out_pal,
        output out_prio,
        output out_transparent
    );

endinterface

// File: rtl/obj_line_bank.sv
// One scanline bank: priority-resolving read-modify-write port, an
// asynchronous read port and a single-entry clear port.
// Build option: OBJ_WINDOW_EN adds the wr_win input and per-entry win bit.
module obj_line_bank
    import obj_line_pkg::*;
#(
    parameter int LINE_WIDTH = OBJ_LINE_WIDTH,
    parameter int XW         = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [XW-1:0]   wr_x,
    input  logic [7:0]      wr_pal,
    input  logic [1:0]      wr_prio,
`ifdef OBJ_WINDOW_EN
    input  logic            wr_win,
`endif
    input  logic [XW-1:0]   rd_x,
    output obj_line_entry_t rd_entry,
    input  logic            clr_en,
    input  logic [XW-1:0]   clr_x
);

    obj_line_entry_t ent_q [LINE_WIDTH];
    obj_line_entry_t wr_cur;
    obj_line_entry_t wr_next;
    logic            wr_hit;
    logic [XW-1:0]   wr_idx;

    // Off-screen columns are dropped; the index is parked at 0 so the
    // read-modify-write lookup never leaves the array.
    assign wr_hit = wr_en && (32'(wr_x) < LINE_WIDTH);
    assign wr_idx = wr_hit ? wr_x : '0;

    // Merge the incoming pixel with what is already stored at that column.
    always_comb begin
        wr_cur  = ent_q[wr_idx];
        wr_next = wr_cur;
`ifdef OBJ_WINDOW_EN
        if (wr_win) begin
            wr_next.win = 1'b1;
        end else if (obj_pixel_wins(wr_cur, wr_prio)) begin
            wr_next.opaque = 1'b1;
            wr_next.prio   = wr_prio;
            wr_next.pal    = wr_pal;
        end
`else
        if (obj_pixel_wins(wr_cur, wr_prio)) begin
            wr_next.opaque = 1'b1;
            wr_next.prio   = wr_prio;
            wr_next.pal    = wr_pal;
        end
`endif
    end

    for (genvar i = 0; i < LINE_WIDTH; i++) begin : g_ent
        obj_line_entry_t ent;

        // Per-column storage; clear wins over write (they never target the
        // same bank in one cycle, so the order only matters for robustness).
        always_ff @(posedge clock) begin
            if (reset) begin
                ent <= '0;
            end else if (clr_en && (clr_x == XW'(i))) begin
                ent <= '0;
            end else if (wr_hit && (wr_x == XW'(i))) begin
                ent <= wr_next;
            end
        end

        assign ent_q[i] = ent;
    end

    assign rd_entry = ent_q[rd_x];

endmodule

// File: rtl/obj_line_streamer.sv
// Double-buffered OBJ scanline buffer. The renderer fills the back bank while
// the front bank is streamed to the compositor and cleared behind the reader.
// Build option: OBJ_WINDOW_EN adds the OBJ-window bit (wr_win / out_win).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line finished or never started; waiting for line_start
// STREAM | presenting front[ptr]; each accept clears it and advances ptr
// FLUSH  | stream aborted by an early line_start; clearing front[ptr..end]
//        | one per cycle, then swapping and streaming the new front bank
module obj_line_streamer
    import obj_line_pkg::*;
#(
    parameter int LINE_WIDTH = OBJ_LINE_WIDTH,
    parameter int XW         = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                line_start,
    obj_line_streamer_if.slave  bus,
    output logic                line_done,
    output logic                busy,
    output logic                overrun
);

    localparam logic [XW-1:0] LAST_X = XW'(LINE_WIDTH - 1);

    obj_stream_state_t state_q, state_nxt;
    logic [XW-1:0]     ptr_q, ptr_nxt;
    logic              bank_sel_q, bank_sel_nxt;
    logic              overrun_q, overrun_nxt;
    logic              line_done_q, line_done_nxt;
    logic              clr_front;
    logic              stream_valid;
    logic              accept;
    logic              at_last;

    obj_line_entry_t   bank0_rd, bank1_rd, front;
    logic              bank0_wr, bank1_wr;
    logic              bank0_clr, bank1_clr;

    // bank_sel names the front bank; writes always land in the other one,
    // using the bank_sel in force this cycle, so a write that coincides with
    // a swap still belongs to the line being started.
    assign bank0_wr  = bus.wr_en & bank_sel_q;
    assign bank1_wr  = bus.wr_en & ~bank_sel_q;
    assign bank0_clr = clr_front & ~bank_sel_q;
    assign bank1_clr = clr_front & bank_sel_q;
    assign front     = bank_sel_q ? bank1_rd : bank0_rd;

    obj_line_bank #(
        .LINE_WIDTH (LINE_WIDTH),
        .XW         (XW)
    ) u_bank0 (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (bank0_wr),
        .wr_x     (bus.wr_x),
        .wr_pal   (bus.wr_pal),
        .wr_prio  (bus.wr_prio),
`ifdef OBJ_WINDOW_EN
        .wr_win   (bus.wr_win),
`endif
        .rd_x     (ptr_q),
        .rd_entry (bank0_rd),
        .clr_en   (bank0_clr),
        .clr_x    (ptr_q)
    );

    obj_line_bank #(
        .LINE_WIDTH (LINE_WIDTH),
        .XW         (XW)
    ) u_bank1 (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (bank1_wr),
        .wr_x     (bus.wr_x),
        .wr_pal   (bus.wr_pal),
        .wr_prio  (bus.wr_prio),
`ifdef OBJ_WINDOW_EN
        .wr_win   (bus.wr_win),
`endif
        .rd_x     (ptr_q),
        .rd_entry (bank1_rd),
        .clr_en   (bank1_clr),
        .clr_x    (ptr_q)
    );

    assign stream_valid = (state_q == STREAM);
    assign accept       = stream_valid & bus.out_ready;
    assign at_last      = (ptr_q == LAST_X);

    // Next-state, pointer, bank swap and sticky overrun decisions.
    always_comb begin
        state_nxt     = state_q;
        ptr_nxt       = ptr_q;
        bank_sel_nxt  = bank_sel_q;
        overrun_nxt   = overrun_q;
        line_done_nxt = 1'b0;
        clr_front     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (line_start) begin
                    bank_sel_nxt = ~bank_sel_q;
                    ptr_nxt      = '0;
                    state_nxt    = STREAM;
                end
            end

            STREAM: begin
                clr_front = accept;
                if (line_start) begin
                    overrun_nxt = 1'b1;
                    if (accept && at_last) begin
                        // Line completed in the same cycle: nothing is left
                        // to flush, so swap straight away.
                        line_done_nxt = 1'b1;
                        bank_sel_nxt  = ~bank_sel_q;
                        ptr_nxt       = '0;
                        state_nxt     = STREAM;
                    end else begin
                        ptr_nxt   = accept ? ptr_q + XW'(1) : ptr_q;
                        state_nxt = FLUSH;
                    end
                end else if (accept) begin
                    if (at_last) begin
                        line_done_nxt = 1'b1;
                        ptr_nxt       = '0;
                        state_nxt     = IDLE;
                    end else begin
                        ptr_nxt = ptr_q + XW'(1);
                    end
                end
            end

            FLUSH: begin
                clr_front = 1'b1;
                if (line_start) begin
                    overrun_nxt = 1'b1;
                end
                if (at_last) begin
                    bank_sel_nxt = ~bank_sel_q;
                    ptr_nxt      = '0;
                    state_nxt    = STREAM;
                end else begin
                    ptr_nxt = ptr_q + XW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            bank_sel_q  <= 1'b0;
            overrun_q   <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            ptr_q       <= ptr_nxt;
            bank_sel_q  <= bank_sel_nxt;
            overrun_q   <= overrun_nxt;
            line_done_q <= line_done_nxt;
        end
    end

    assign bus.out_valid       = stream_valid;
    assign bus.out_x           = ptr_q;
    assign bus.out_pal         = (stream_valid && front.opaque) ? front.pal  : 8'h00;
    assign bus.out_prio        = (stream_valid && front.opaque) ? front.prio : 2'd0;
    assign bus.out_transparent = !(stream_valid && front.opaque);
`ifdef OBJ_WINDOW_EN
    assign bus.out_win         = stream_valid & front.win;
`endif

    assign line_done = line_done_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_obj_line_streamer.sv
// Self-checking bench for obj_line_streamer against a per-bank array model.
module tb_obj_line_streamer;

    localparam int LW = 240;

    logic clock = 1'b0;
    logic reset;
    logic line_start;
    logic line_done;
    logic busy;
    logic overrun;

    obj_line_streamer_if #(.XW(8)) bus ();

    obj_line_streamer #(.LINE_WIDTH(LW), .XW(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .line_start (line_start),
        .bus        (bus),
        .line_done  (line_done),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: m_sel is the front bank; the back bank is 1 - m_sel.
    int m_opq  [2][LW];
    int m_prio [2][LW];
    int m_pal  [2][LW];
    int m_win  [2][LW];
    int m_sel;

    int cap_pal  [LW];
    int cap_prio [LW];
    int cap_tr   [LW];
    int cap_win  [LW];

    int ready_pat [4] = '{1, 0, 0, 1};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void model_write(int x, int pal, int prio, int win);
        int b;
        if (x >= LW) return;
        b = 1 - m_sel;
        if (win != 0) begin
            m_win[b][x] = 1;
        end else if (m_opq[b][x] == 0 || prio < m_prio[b][x]) begin
            m_opq[b][x]  = 1;
            m_prio[b][x] = prio;
            m_pal[b][x]  = pal;
        end
    endfunction

    function automatic void model_clear(int b, int x);
        m_opq[b][x]  = 0;
        m_prio[b][x] = 0;
        m_pal[b][x]  = 0;
        m_win[b][x]  = 0;
    endfunction

    task automatic drive_write(input int x, input int pal, input int prio, input int win);
        bus.wr_en   = 1'b1;
        bus.wr_x    = 8'(x);
        bus.wr_pal  = 8'(pal);
        bus.wr_prio = 2'(prio);
`ifdef OBJ_WINDOW_EN
        bus.wr_win  = (win != 0);
        model_write(x, pal, prio, win);
`else
        model_write(x, pal, prio, 0);
        if (win != 0) $display("note: window write requested in default build, sent as normal pixel");
`endif
    endtask

    task automatic idle_bus();
        bus.wr_en = 1'b0;
`ifdef OBJ_WINDOW_EN
        bus.wr_win = 1'b0;
`endif
    endtask

    task automatic check_pixel(input int idx);
        int b = m_sel;
        check_val("out_valid", bus.out_valid, 1);
        check_val("out_x", bus.out_x, idx);
        check_val("out_pal", bus.out_pal, m_opq[b][idx] != 0 ? m_pal[b][idx] : 0);
        check_val("out_prio", bus.out_prio, m_opq[b][idx] != 0 ? m_prio[b][idx] : 0);
        check_val("out_transparent", bus.out_transparent, m_opq[b][idx] == 0 ? 1 : 0);
`ifdef OBJ_WINDOW_EN
        check_val("out_win", bus.out_win, m_win[b][idx]);
`endif
        check_val("line_done_early", line_done, 0);
    endtask

    task automatic start_line(input bit do_wr, input int x, input int pal, input int prio);
        line_start = 1'b1;
        if (do_wr) drive_write(x, pal, prio, 0);
        m_sel = 1 - m_sel;
        tick();
        line_start = 1'b0;
        idle_bus();
        check_val("start_valid", bus.out_valid, 1);
        check_val("start_x", bus.out_x, 0);
        check_val("start_busy", busy, 1);
    endtask

    // mode 0: always ready, 1: 1,0,0,1 pattern, 2: random ready.
    task automatic stream_line(input int mode, input bit rnd_wr, input int abort_at, output bit aborted);
        int  idx = 0;
        int  cyc = 0;
        bit  rdy;
        aborted = 1'b0;
        while (idx < LW && cyc < 4 * LW) begin
            check_pixel(idx);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (ready_pat[cyc % 4] != 0);
                default: rdy = ($urandom_range(0, 1) != 0);
            endcase
            if (idx == abort_at) begin
                rdy        = 1'b0;
                line_start = 1'b1;
            end else if (rnd_wr && $urandom_range(0, 2) == 0) begin
`ifdef OBJ_WINDOW_EN
                drive_write($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3),
                            ($urandom_range(0, 3) == 0) ? 1 : 0);
`else
                drive_write($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), 0);
`endif
            end
            bus.out_ready = rdy;
            if (rdy) begin
                cap_pal[idx]  = bus.out_pal;
                cap_prio[idx] = bus.out_prio;
                cap_tr[idx]   = bus.out_transparent;
`ifdef OBJ_WINDOW_EN
                cap_win[idx]  = bus.out_win;
`endif
            end
            tick();
            line_start = 1'b0;
            idle_bus();
            if (idx == abort_at) begin
                aborted = 1'b1;
                bus.out_ready = 1'b0;
                return;
            end
            if (rdy) begin
                model_clear(m_sel, idx);
                idx++;
            end
            cyc++;
        end
        bus.out_ready = 1'b0;
        check_val("line_complete", idx, LW);
        check_val("line_done_pulse", line_done, 1);
        check_val("end_busy", busy, 0);
        check_val("end_valid", bus.out_valid, 0);
        tick();
        check_val("line_done_single", line_done, 0);
    endtask

    task automatic flush_and_restart();
        int n = 0;
        for (int x = 0; x < LW; x++) model_clear(m_sel, x);
        m_sel = 1 - m_sel;
        check_val("overrun_set", overrun, 1);
        check_val("abort_valid_drop", bus.out_valid, 0);
        while (bus.out_valid == 1'b0 && n < 400) begin
            if (n == 50) line_start = 1'b1;
            tick();
            line_start = 1'b0;
            n++;
        end
        check_val("flush_len", n, 140);
        check_val("restart_x", bus.out_x, 0);
        check_val("overrun_sticky", overrun, 1);
    endtask

    initial begin
        bit ab;
        int ntr;

        line_start    = 1'b0;
        bus.out_ready = 1'b0;
        bus.wr_x      = '0;
        bus.wr_pal    = '0;
        bus.wr_prio   = '0;
        idle_bus();
        reset = 1'b1;
        m_sel = 0;
        for (int b = 0; b < 2; b++)
            for (int x = 0; x < LW; x++) model_clear(b, x);
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        tick();

        check_val("rst_valid", bus.out_valid, 0);
        check_val("rst_x", bus.out_x, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_overrun", overrun, 0);
        check_val("rst_line_done", line_done, 0);

        // Empty line, always ready.
        start_line(1'b0, 0, 0, 0);
        stream_line(0, 1'b0, -1, ab);
        ntr = 0;
        for (int x = 0; x < LW; x++) ntr += cap_tr[x];
        check_val("empty_line_transparent", ntr, LW);

        // Priority arbitration, off-screen write, write coincident with swap.
        drive_write(5, 8'h23, 2, 0); tick();
        drive_write(5, 8'h41, 1, 0); tick();
        drive_write(5, 8'h77, 1, 0); tick();
        drive_write(240, 8'h99, 0, 0); tick();
        idle_bus();
        start_line(1'b1, 0, 8'h5A, 3);
        stream_line(1, 1'b0, -1, ab);
        check_val("x5_pal", cap_pal[5], 8'h41);
        check_val("x5_prio", cap_prio[5], 1);
        check_val("x0_swap_write", cap_pal[0], 8'h5A);
        check_val("x0_opaque", cap_tr[0], 0);

        // Random writes and random back-pressure.
        for (int l = 0; l < 3; l++) begin
            start_line(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3));
            stream_line(2, 1'b1, -1, ab);
        end

        // Early line_start at x=100, flush, restart, then old bank is empty.
        start_line(1'b0, 0, 0, 0);
        stream_line(2, 1'b1, 100, ab);
        check_val("abort_reached", ab, 1);
        if (ab) begin
            flush_and_restart();
            stream_line(0, 1'b0, -1, ab);
            start_line(1'b0, 0, 0, 0);
            stream_line(0, 1'b0, -1, ab);
            ntr = 0;
            for (int x = 0; x < LW; x++) ntr += cap_tr[x];
            check_val("old_bank_transparent", ntr, LW);
        end

`ifdef OBJ_WINDOW_EN
        drive_write(7, 8'h12, 0, 0); tick();
        drive_write(7, 8'h55, 3, 1); tick();
        idle_bus();
        start_line(1'b0, 0, 0, 0);
        stream_line(0, 1'b0, -1, ab);
        check_val("win_set", cap_win[7], 1);
        check_val("win_pal_kept", cap_pal[7], 8'h12);
        start_line(1'b0, 0, 0, 0);
        stream_line(0, 1'b0, -1, ab);
        start_line(1'b0, 0, 0, 0);
        stream_line(0, 1'b0, -1, ab);
        check_val("win_cleared", cap_win[7], 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
